// File: rtl/binary_up_counter.sv
// rtl/binary_up_counter.sv - free-running binary up-counter with Gray copy, wrap pulse and wrap tally
// Side-band status (tc, wrap, wrap_cnt) is for downstream timing and sequencing logic.
module binary_up_counter #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  parameter int                 WRAP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [WIDTH-1:0]  count,
  output logic [WIDTH-1:0]  count_gray,
  output logic              tc,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [WIDTH-1:0]  MAX_VAL  = '1;
  localparam logic [WRAP_W-1:0] TALLY_MAX = '1;

  logic [WIDTH-1:0]  r_count;
  logic [WIDTH-1:0]  r_gray;
  logic              r_wrap;
  logic [WRAP_W-1:0] r_wrap_cnt;

  logic [WIDTH-1:0]  w_next;
  logic              w_at_max;
  logic              w_tally_full;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign w_at_max     = (r_count == MAX_VAL);
  assign w_tally_full = (r_wrap_cnt == TALLY_MAX);
  assign w_next       = r_count + WIDTH'(1);

  // Gray is derived from the next count so it lands on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= RST_VAL;
      r_gray     <= to_gray(RST_VAL);
      r_wrap     <= 1'b0;
      r_wrap_cnt <= '0;
    end else begin
      r_count <= w_next;
      r_gray  <= to_gray(w_next);
      r_wrap  <= w_at_max;
      if (w_at_max && !w_tally_full) begin
        r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
      end
    end
  end

  assign count      = r_count;
  assign count_gray = r_gray;
  assign tc         = w_at_max;
  assign wrap       = r_wrap;
  assign wrap_cnt   = r_wrap_cnt;

endmodule

// File: tb/tb_binary_up_counter.sv
// tb/tb_binary_up_counter.sv - scoreboard bench for binary_up_counter
// Two instances share clk/rst: default tally width and a 2-bit tally for saturation.
module tb_binary_up_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [3:0] count, count_gray;
  logic       tc, wrap;
  logic [7:0] wrap_cnt;

  logic [3:0] s_count, s_gray;
  logic       s_tc, s_wrap;
  logic [1:0] s_wrap_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int n_spulse = 0;

  typedef struct {
    logic [3:0] c;
    logic [3:0] g;
    logic       tc;
    logic       w;
    logic [7:0] wc;
    logic [1:0] swc;
  } exp_t;

  exp_t sb[$];

  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  logic [3:0] m_c;
  logic       m_w;
  logic [7:0] m_wc;
  logic [1:0] m_swc;

  binary_up_counter #(.WIDTH(4), .RST_VAL(4'd0), .WRAP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .count_gray (count_gray),
    .tc         (tc),
    .wrap       (wrap),
    .wrap_cnt   (wrap_cnt)
  );

  binary_up_counter #(.WIDTH(4), .RST_VAL(4'd0), .WRAP_W(2)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .count      (s_count),
    .count_gray (s_gray),
    .tc         (s_tc),
    .wrap       (s_wrap),
    .wrap_cnt   (s_wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r);
    exp_t e;
    rst = r;
    if (r) begin
      m_c = 4'd0; m_w = 1'b0; m_wc = 8'd0; m_swc = 2'd0;
    end else begin
      m_w = (m_c == 4'd15);
      if (m_w && m_wc != 8'hFF) m_wc = m_wc + 8'd1;
      if (m_w && m_swc != 2'd3) m_swc = m_swc + 2'd1;
      m_c = m_c + 4'd1;
    end
    e.c = m_c; e.g = gtab[m_c]; e.tc = (m_c == 4'd15);
    e.w = m_w; e.wc = m_wc; e.swc = m_swc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("count", 32'(count), 32'(e.c));
      check("count_gray", 32'(count_gray), 32'(e.g));
      check("tc", 32'(tc), 32'(e.tc));
      check("wrap", 32'(wrap), 32'(e.w));
      check("wrap_cnt", 32'(wrap_cnt), 32'(e.wc));
      check("sat_wrap_cnt", 32'(s_wrap_cnt), 32'(e.swc));
      check("sat_wrap", 32'(s_wrap), 32'(e.w));
      if (s_wrap) n_spulse++;
    end
  endtask

  initial begin
    // Reset hold
    step(1'b1);
    step(1'b1);
    check("rst_count", 32'(count), 32'h0);
    check("rst_gray", 32'(count_gray), 32'h0);
    check("rst_tc", 32'(tc), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_wrap_cnt", 32'(wrap_cnt), 32'h0);

    // Count-up: 10 edges after release
    for (int i = 0; i < 10; i++) step(1'b0);
    check("cnt10_count", 32'(count), 32'hA);
    check("cnt10_gray", 32'(count_gray), 32'hF);

    // Wrap
    for (int i = 0; i < 5; i++) step(1'b0);
    check("max_count", 32'(count), 32'hF);
    check("max_tc", 32'(tc), 32'h1);
    step(1'b0);
    check("wrap_count", 32'(count), 32'h0);
    check("wrap_pulse", 32'(wrap), 32'h1);
    check("wrap_tally", 32'(wrap_cnt), 32'h1);
    step(1'b0);
    check("wrap_one_cycle", 32'(wrap), 32'h0);

    // Reset mid-count at 7
    for (int i = 0; i < 6; i++) step(1'b0);
    check("mid_pre", 32'(count), 32'h7);
    step(1'b1);
    check("mid_rst", 32'(count), 32'h0);
    step(1'b0);
    check("mid_release", 32'(count), 32'h1);

    // Reset on the wrap edge
    for (int i = 0; i < 14; i++) step(1'b0);
    check("rw_pre_tc", 32'(tc), 32'h1);
    step(1'b1);
    check("rw_count", 32'(count), 32'h0);
    check("rw_wrap", 32'(wrap), 32'h0);
    check("rw_tally", 32'(wrap_cnt), 32'h0);

    // Saturation of the 2-bit tally over 5 wraps
    n_spulse = 0;
    for (int i = 0; i < 80; i++) step(1'b0);
    step(1'b0);
    check("sat_tally", 32'(s_wrap_cnt), 32'h3);
    check("sat_pulses", 32'(n_spulse), 32'd5);
    check("wide_tally", 32'(wrap_cnt), 32'd5);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
